// File: rtl/add_sched_pkg.sv
// Shared widths and the in-flight tag record for the add_sched adder scheduler.
package add_sched_pkg;

  localparam int ADD_W  = 32;
  localparam int ID_W   = 2;
  localparam int STAT_W = 16;

  typedef struct packed {
    logic            valid;
    logic [ID_W-1:0] id;
  } tag_t;

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin pick over N_REQ requests, searching upward from last_grant+1 with wrap.
module rr_arbiter
  import add_sched_pkg::*;
#(
  parameter int N_REQ = 2
) (
  input  logic [N_REQ-1:0] req,
  input  logic [ID_W-1:0]  last_grant,
  input  logic             en,
  output logic [N_REQ-1:0] gnt,
  output logic [ID_W-1:0]  gnt_id,
  output logic             gnt_any
);

  // Outer loop walks priority order; the first hit blocks every later candidate.
  always_comb begin
    gnt     = '0;
    gnt_id  = '0;
    gnt_any = 1'b0;
    for (int k = 1; k <= N_REQ; k++) begin
      for (int i = 0; i < N_REQ; i++) begin
        if (en && !gnt_any && req[i] && (i == (int'(last_grant) + k) % N_REQ)) begin
          gnt[i]  = 1'b1;
          gnt_id  = ID_W'(i);
          gnt_any = 1'b1;
        end
      end
    end
  end

endmodule

// File: rtl/add_sched.sv
// Shares one LAT-stage pipelined adder between N_REQ requesters with tag tracking and backpressure.
// Optional per-requester completion counters are built when ADD_SCHED_STATS_EN is defined.
module add_sched
  import add_sched_pkg::*;
#(
  parameter int N_REQ = 2,
  parameter int LAT   = 4
) (
  input  logic                   clk,
  input  logic                   rst_n,
  // Handshakes: a transfer happens on a rising edge where valid and ready are both high;
  // ready never depends on the same requester's valid being held beyond that cycle.
  input  logic [N_REQ-1:0]       req_valid,
  output logic [N_REQ-1:0]       req_ready,
  input  logic [N_REQ*ADD_W-1:0] req_a,
  input  logic [N_REQ*ADD_W-1:0] req_b,
  input  logic [N_REQ-1:0]       req_cin,
  input  logic                   flush,
  output logic [ADD_W-1:0]       add_a,
  output logic [ADD_W-1:0]       add_b,
  output logic                   add_cin,
  output logic                   add_stop,
  output logic                   add_new,
  input  logic [ADD_W-1:0]       add_sum,
  input  logic                   add_cout,
  output logic [N_REQ-1:0]       rsp_valid,
  input  logic [N_REQ-1:0]       rsp_ready,
  output logic [ADD_W-1:0]       rsp_sum,
  output logic                   rsp_cout,
  output logic                   busy
`ifdef ADD_SCHED_STATS_EN
  ,
  output logic [N_REQ*STAT_W-1:0] stat_cnt
`endif
);

  tag_t             tags [LAT];
  tag_t             head;
  logic [ID_W-1:0]  last_grant;
  logic             rst_seen;
  logic             kill;
  logic             head_ready;
  logic             stall;
  logic [N_REQ-1:0] gnt;
  logic [ID_W-1:0]  gnt_id;
  logic             gnt_any;

  assign head = tags[LAT-1];

  // The first cycle out of reset behaves like a flush so the adder's stale stages get cleared.
  assign kill    = flush | ~rst_seen;
  assign add_new = rst_n & kill;

  always_comb begin
    head_ready = 1'b0;
    rsp_valid  = '0;
    for (int i = 0; i < N_REQ; i++) begin
      if (head.id == ID_W'(i)) begin
        head_ready   = rsp_ready[i];
        rsp_valid[i] = head.valid & ~kill;
      end
    end
  end

  assign stall    = head.valid & ~head_ready;
  assign add_stop = stall & ~kill;

  rr_arbiter #(.N_REQ(N_REQ)) u_arb (
    .req        (req_valid),
    .last_grant (last_grant),
    .en         (~stall & ~kill),
    .gnt        (gnt),
    .gnt_id     (gnt_id),
    .gnt_any    (gnt_any)
  );

  assign req_ready = gnt;
  assign rsp_sum   = add_sum;
  assign rsp_cout  = add_cout;

  always_comb begin
    add_a   = '0;
    add_b   = '0;
    add_cin = 1'b0;
    for (int i = 0; i < N_REQ; i++) begin
      if (gnt[i]) begin
        add_a   = req_a[ADD_W*i +: ADD_W];
        add_b   = req_b[ADD_W*i +: ADD_W];
        add_cin = req_cin[i];
      end
    end
  end

  always_comb begin
    busy = 1'b0;
    for (int i = 0; i < LAT; i++) busy = busy | tags[i].valid;
  end

  // The tag pipe advances in lockstep with the adder: it holds exactly when add_stop freezes it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < LAT; i++) tags[i] <= '0;
      last_grant <= ID_W'(N_REQ - 1);
      rst_seen   <= 1'b0;
    end else begin
      rst_seen <= 1'b1;
      if (kill) begin
        for (int i = 0; i < LAT; i++) tags[i] <= '0;
      end else if (!stall) begin
        for (int i = LAT - 1; i > 0; i--) tags[i] <= tags[i-1];
        tags[0] <= '{valid: gnt_any, id: gnt_id};
        if (gnt_any) last_grant <= gnt_id;
      end
    end
  end

`ifdef ADD_SCHED_STATS_EN
  logic [STAT_W-1:0] cnt [N_REQ];
  logic              retire;

  assign retire = head.valid & head_ready & ~kill;

  // Saturating counters survive flush; only reset clears them.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < N_REQ; i++) cnt[i] <= '0;
    end else begin
      for (int i = 0; i < N_REQ; i++) begin
        if (retire && head.id == ID_W'(i) && cnt[i] != {STAT_W{1'b1}}) cnt[i] <= cnt[i] + 1'b1;
      end
    end
  end

  always_comb begin
    stat_cnt = '0;
    for (int i = 0; i < N_REQ; i++) stat_cnt[STAT_W*i +: STAT_W] = cnt[i];
  end
`endif

endmodule

// File: tb/tb_add_sched.sv
// Self-checking bench for add_sched driving a behavioural 4-stage stop/new adder model.
module tb_add_sched;

  localparam int N   = 2;
  localparam int LAT = 4;

  logic            clk = 1'b0;
  logic            rst_n;
  logic [N-1:0]    req_valid, req_ready, req_cin, rsp_valid, rsp_ready;
  logic [N*32-1:0] req_a, req_b;
  logic            flush;
  logic [31:0]     add_a, add_b, add_sum, rsp_sum;
  logic            add_cin, add_stop, add_new, add_cout, rsp_cout, busy;
`ifdef ADD_SCHED_STATS_EN
  logic [N*16-1:0] stat_cnt;
`endif

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int stop_cnt = 0;
  int ret_cnt [N];
  int rsp_cyc [$];
  logic [34:0] exp_q [$];   // {id[1:0], cout, sum}

  typedef struct {
    int          id;
    logic [31:0] a;
    logic [31:0] b;
    logic        cin;
    logic [31:0] exp_sum;
    logic        exp_cout;
  } vec_t;

  vec_t vecs [6];

  // ---------------- clock / reset / DUT ----------------
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  add_sched #(.N_REQ(N), .LAT(LAT)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_a     (req_a),
    .req_b     (req_b),
    .req_cin   (req_cin),
    .flush     (flush),
    .add_a     (add_a),
    .add_b     (add_b),
    .add_cin   (add_cin),
    .add_stop  (add_stop),
    .add_new   (add_new),
    .add_sum   (add_sum),
    .add_cout  (add_cout),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_sum   (rsp_sum),
    .rsp_cout  (rsp_cout),
    .busy      (busy)
`ifdef ADD_SCHED_STATS_EN
    ,
    .stat_cnt  (stat_cnt)
`endif
  );

  // Behavioural adder: new clears every stage, stop freezes every stage.
  logic [32:0] apipe [LAT];
  always @(posedge clk) begin
    if (add_new) begin
      for (int i = 0; i < LAT; i++) apipe[i] <= '0;
    end else if (!add_stop) begin
      apipe[0] <= {1'b0, add_a} + {1'b0, add_b} + 33'(add_cin);
      for (int i = 1; i < LAT; i++) apipe[i] <= apipe[i-1];
    end
  end
  assign add_sum  = apipe[LAT-1][31:0];
  assign add_cout = apipe[LAT-1][32];

  // ---------------- checking helpers ----------------
  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic fail_now(input string name);
    checks++;
    errors++;
    $display("FAIL %s: event did not occur (cycle %0d)", name, cyc);
  endtask

  function automatic logic [32:0] add33(input logic [31:0] a, input logic [31:0] b, input logic c);
    return {1'b0, a} + {1'b0, b} + 33'(c);
  endfunction

  // ---------------- scoreboard ----------------
  // Results must come back in issue order, to the issuing requester, with a+b+cin.
  always @(negedge clk) begin
    if (!rst_n) begin
      exp_q.delete();
      for (int i = 0; i < N; i++) ret_cnt[i] = 0;
    end else if (flush) begin
      check("flush_rsp_valid", 64'(rsp_valid), 0);
      check("flush_req_ready", 64'(req_ready), 0);
      check("flush_add_new", 64'(add_new), 1);
      exp_q.delete();
    end else begin
      for (int i = 0; i < N; i++) begin
        if (req_valid[i] && req_ready[i])
          exp_q.push_back({2'(i), add33(req_a[32*i +: 32], req_b[32*i +: 32], req_cin[i])});
      end
      if (add_stop) begin
        stop_cnt++;
        check("stall_no_grant", 64'(req_ready), 0);
      end
      if (rsp_valid != 0) check("rsp_onehot", 64'($onehot(rsp_valid)), 1);
      for (int i = 0; i < N; i++) begin
        if (rsp_valid[i] && rsp_ready[i]) begin
          logic [34:0] e;
          rsp_cyc.push_back(cyc);
          if (exp_q.size() == 0) begin
            fail_now("rsp_unexpected");
          end else begin
            e = exp_q.pop_front();
            check("rsp_id", 64'(i), 64'(e[34:33]));
            check("rsp_result", 64'({rsp_cout, rsp_sum}), 64'(e[32:0]));
            ret_cnt[i]++;
          end
        end
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic rand_ops(input int i);
    req_a[32*i +: 32] = ($urandom_range(0, 3) == 0) ? 32'hFFFF_FFFF : $urandom();
    req_b[32*i +: 32] = ($urandom_range(0, 3) == 0) ? 32'h0000_0001 : $urandom();
    req_cin[i]        = 1'($urandom_range(0, 1));
  endtask

  task automatic drain(input int n);
    repeat (n) step();
  endtask

  task automatic run_vec(input vec_t v);
    int lat;
    bit got;
    req_valid = '0;
    req_valid[v.id] = 1'b1;
    req_a[32*v.id +: 32] = v.a;
    req_b[32*v.id +: 32] = v.b;
    req_cin[v.id] = v.cin;
    got = 1'b0;
    for (int t = 0; t < 20 && !got; t++) begin
      @(negedge clk);
      if (req_ready[v.id]) got = 1'b1;
      step();
    end
    req_valid = '0;
    if (!got) begin
      fail_now("vec_accept_timeout");
      return;
    end
    lat = 1;
    got = 1'b0;
    for (int t = 0; t < 20 && !got; t++) begin
      @(negedge clk);
      if (rsp_valid != 0) got = 1'b1;
      else begin
        step();
        lat++;
      end
    end
    if (!got) begin
      fail_now("vec_rsp_timeout");
      return;
    end
    check("vec_latency", 64'(lat), LAT);
    check("vec_rsp_valid", 64'(rsp_valid), 64'(1 << v.id));
    check("vec_sum", 64'(rsp_sum), 64'(v.exp_sum));
    check("vec_cout", 64'(rsp_cout), 64'(v.exp_cout));
    step();
  endtask

  // Both requesters compete for n consecutive cycles; grants must alternate.
  task automatic accept_alt(input int n, input int first);
    int g;
    for (int i = 0; i < N; i++) rand_ops(i);
    req_valid = '1;
    for (int k = 0; k < n; k++) begin
      @(negedge clk);
      check("grant_order", 64'(req_ready), 64'(1 << ((first + k) % N)));
      g = (req_ready[1]) ? 1 : 0;
      step();
      rand_ops(g);
    end
    req_valid = '0;
  endtask

  task automatic reset_seq();
    req_valid = '1;
    rst_n = 1'b0;
    @(negedge clk);
    check("rst_busy", 64'(busy), 0);
    check("rst_rsp_valid", 64'(rsp_valid), 0);
    check("rst_req_ready", 64'(req_ready), 0);
    check("rst_add_stop", 64'(add_stop), 0);
    check("rst_add_new", 64'(add_new), 0);
    check("rst_add_ops", 64'({add_cin, add_a, add_b}), 0);
`ifdef ADD_SCHED_STATS_EN
    check("rst_stat_cnt", 64'(stat_cnt), 0);
`endif
    step();
    rst_n = 1'b1;
    @(negedge clk);
    check("rel_add_new_pulse", 64'(add_new), 1);
    check("rel_no_grant", 64'(req_ready), 0);
    step();
    @(negedge clk);
    check("rel_add_new_once", 64'(add_new), 0);
    check("rel_first_grant", 64'(req_ready), 1);
    step();
    req_valid = '0;
    drain(8);
    check("rel_drained", 64'(exp_q.size()), 0);
  endtask

  // ---------------- test sequence ----------------
  initial begin
    vecs[0] = '{0, 32'h34AA_F8D5, 32'h34AA_F8D5, 1'b0, 32'h6955_F1AA, 1'b0};
    vecs[1] = '{1, 32'hFFFF_FFFF, 32'h0000_0001, 1'b0, 32'h0000_0000, 1'b1};
    vecs[2] = '{0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1, 32'hFFFF_FFFF, 1'b1};
    vecs[3] = '{1, 32'h0000_0000, 32'h0000_0000, 1'b1, 32'h0000_0001, 1'b0};
    vecs[4] = '{0, 32'h8000_0000, 32'h8000_0000, 1'b0, 32'h0000_0000, 1'b1};
    vecs[5] = '{1, 32'h1234_5678, 32'h8765_4321, 1'b1, 32'h9999_999A, 1'b0};

    rst_n = 1'b0;
    req_valid = '0;
    req_a = '0;
    req_b = '0;
    req_cin = '0;
    rsp_ready = '1;
    flush = 1'b0;
    for (int i = 0; i < N; i++) rand_ops(i);
    step();

    reset_seq();

    // Table of single operations, each with latency and payload checked.
    foreach (vecs[i]) run_vec(vecs[i]);

    // Fairness: six alternating grants, six back-to-back results.
    rsp_cyc.delete();
    accept_alt(6, 0);
    drain(8);
    check("fair_rsp_count", 64'(rsp_cyc.size()), 6);
    if (rsp_cyc.size() == 6) check("fair_rsp_back_to_back", 64'(rsp_cyc[5] - rsp_cyc[0]), 5);
    check("fair_drained", 64'(exp_q.size()), 0);

    // Backpressure: requester 0 refuses its result for three cycles.
    begin
      bit got;
      rsp_ready = 2'b10;
      stop_cnt = 0;
      accept_alt(4, 0);
      got = 1'b0;
      for (int t = 0; t < 20 && !got; t++) begin
        @(negedge clk);
        if (rsp_valid[0]) got = 1'b1;
        else step();
      end
      if (!got) fail_now("bp_head_timeout");
      for (int j = 0; j < 3; j++) begin
        if (j > 0) @(negedge clk);
        check("bp_add_stop", 64'(add_stop), 1);
        check("bp_no_grant", 64'(req_ready), 0);
        step();
        if (j == 0) begin
          rand_ops(1);
          req_valid[1] = 1'b1;
        end
      end
      rsp_ready = 2'b11;
      @(negedge clk);
      check("bp_release_stop", 64'(add_stop), 0);
      check("bp_release_grant", 64'(req_ready), 2'b10);
      step();
      req_valid = '0;
      drain(10);
      check("bp_stop_cycles", 64'(stop_cnt), 3);
      check("bp_drained", 64'(exp_q.size()), 0);
    end

    // Flush with three operations in flight.
    accept_alt(3, 0);
    rsp_cyc.delete();
    flush = 1'b1;
    @(negedge clk);
    check("flush_new_pulse", 64'(add_new), 1);
    step();
    flush = 1'b0;
    @(negedge clk);
    check("flush_busy_cleared", 64'(busy), 0);
    check("flush_new_once", 64'(add_new), 0);
    drain(8);
    check("flush_no_results", 64'(rsp_cyc.size()), 0);
    run_vec(vecs[0]);

    // Reset with two operations in flight.
    accept_alt(2, 1);
    reset_seq();

    // Randomized traffic with backpressure and occasional flush.
    for (int c = 0; c < 400; c++) begin
      req_valid = N'($urandom_range(0, (1 << N) - 1));
      for (int i = 0; i < N; i++) begin
        rand_ops(i);
        rsp_ready[i] = ($urandom_range(0, 3) != 0);
      end
      flush = ($urandom_range(0, 39) == 0);
      step();
    end
    req_valid = '0;
    rsp_ready = '1;
    flush = 1'b0;
    drain(20);
    check("rand_drained", 64'(exp_q.size()), 0);
    @(negedge clk);
    check("rand_idle", 64'(busy), 0);
`ifdef ADD_SCHED_STATS_EN
    for (int i = 0; i < N; i++) check("stat_cnt", 64'(stat_cnt[16*i +: 16]), 64'(ret_cnt[i]));
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish (cycle %0d)", cyc);
    $fatal(1, "watchdog expired");
  end

endmodule
